// File: rtl/register_file_ctl.sv
// Parametrised register bank with a sequential clear engine that zeroes every entry
// after reset or on request, plus an optional hardwired zero register and write bypass.
module register_file_ctl #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_READ = 2,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ClearReq,
  input  logic                         RegWrite,
  input  logic [ADDR_W-1:0]            WriteReg,
  input  logic [DATA_W-1:0]            WriteData,
  input  logic [NUM_READ*ADDR_W-1:0]   ReadReg,
  output logic [NUM_READ*DATA_W-1:0]   ReadData,
  output logic                         Ready,
  output logic                         WriteDropped
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] CntLast = Depth[ADDR_W:0] - 1'b1;

  typedef enum logic [0:0] {StClear, StReady} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                drop_q, drop_d;
  logic [DATA_W-1:0]   mem_q [Depth];

  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [ADDR_W-1:0]   rd_addr;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drop_d  = 1'b0;
    wr_en   = 1'b0;
    wr_addr = WriteReg;
    wr_data = WriteData;
    unique case (state_q)
      StClear: begin
        // Sweep one entry per cycle; external writes are refused meanwhile.
        wr_en   = 1'b1;
        wr_addr = cnt_q[ADDR_W-1:0];
        wr_data = '0;
        cnt_d   = cnt_q + 1'b1;
        drop_d  = RegWrite;
        if (cnt_q == CntLast) begin
          state_d = StReady;
        end
      end
      StReady: begin
        if (ClearReq) begin
          state_d = StClear;
          cnt_d   = '0;
          drop_d  = RegWrite;
        end else if (RegWrite && !(ZERO_REG && (WriteReg == '0))) begin
          wr_en = 1'b1;
        end
      end
      default: begin
        state_d = StClear;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StClear;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end

  // Storage is deliberately left out of reset; the sweep clears it.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign Ready        = (state_q == StReady);
  assign WriteDropped = drop_q;

  always_comb begin
    ReadData = '0;
    rd_addr  = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      rd_addr = ReadReg[i*ADDR_W +: ADDR_W];
      if (!Ready) begin
        ReadData[i*DATA_W +: DATA_W] = '0;
      end else if (ZERO_REG && (rd_addr == '0)) begin
        ReadData[i*DATA_W +: DATA_W] = '0;
      end else if (BYPASS && RegWrite && !ClearReq && (WriteReg == rd_addr)) begin
        ReadData[i*DATA_W +: DATA_W] = WriteData;
      end else begin
        ReadData[i*DATA_W +: DATA_W] = mem_q[rd_addr];
      end
    end
  end

endmodule

// File: tb/tb_register_file_ctl.sv
// Directed bench: dut_a uses ZERO_REG=1/BYPASS=1, dut_b uses ZERO_REG=0/BYPASS=0,
// both driven by the same stimulus.
module tb_register_file_ctl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ClearReq;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [9:0]  ReadReg;
  logic [63:0] rd_a, rd_b;
  logic        ready_a, ready_b, drop_a, drop_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  register_file_ctl #(
    .DATA_W(32), .ADDR_W(5), .NUM_READ(2), .ZERO_REG(1'b1), .BYPASS(1'b1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .ClearReq(ClearReq), .RegWrite(RegWrite),
    .WriteReg(WriteReg), .WriteData(WriteData), .ReadReg(ReadReg),
    .ReadData(rd_a), .Ready(ready_a), .WriteDropped(drop_a)
  );

  register_file_ctl #(
    .DATA_W(32), .ADDR_W(5), .NUM_READ(2), .ZERO_REG(1'b0), .BYPASS(1'b0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .ClearReq(ClearReq), .RegWrite(RegWrite),
    .WriteReg(WriteReg), .WriteData(WriteData), .ReadReg(ReadReg),
    .ReadData(rd_b), .Ready(ready_b), .WriteDropped(drop_b)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [4:0] p0, input logic [4:0] p1);
    ReadReg = {p1, p0};
    #1;
  endtask

  // Counts edges until Ready rises, bounded; a missing rise shows up as rise=0.
  task automatic wait_ready(input string tag, input int exp_cyc);
    int rise;
    rise = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (ready_a && rise == 0) rise = i;
      if (rise != 0) break;
    end
    check_eq(tag, rise, exp_cyc);
    check_eq({tag, "_b"}, ready_b, 1'b1);
  endtask

  initial begin
    rst_n     = 1'b0;
    ClearReq  = 1'b0;
    RegWrite  = 1'b0;
    WriteReg  = '0;
    WriteData = '0;
    ReadReg   = '0;

    // Test 1: reset, sweep length, writes dropped while clearing
    repeat (3) step();
    check_eq("rst_ready", ready_a, 1'b0);
    check_eq("rst_drop", drop_a, 1'b0);
    rst_n     = 1'b1;
    RegWrite  = 1'b1;
    WriteReg  = 5'd9;
    WriteData = 32'hFFFF_FFFF;
    set_rd(5'd9, 5'd9);
    check_eq("clr_read_zero", rd_a, 64'h0);
    step();
    check_eq("clr_drop", drop_a, 1'b1);
    check_eq("clr_drop_b", drop_b, 1'b1);
    check_eq("clr_ready", ready_a, 1'b0);
    wait_ready("rise_reset", 31);
    RegWrite = 1'b0;
    check_eq("last_clr_drop", drop_a, 1'b1);
    set_rd(5'd9, 5'd8);
    check_eq("e9_untouched_a", rd_a, 64'h0);
    check_eq("e9_untouched_b", rd_b, 64'h0);
    step();
    check_eq("drop_clears", drop_a, 1'b0);

    // Test 2: basic write, dual-port read of same entry
    RegWrite  = 1'b1;
    WriteReg  = 5'd7;
    WriteData = 32'hDEAD_BEEF;
    step();
    RegWrite = 1'b0;
    set_rd(5'd7, 5'd7);
    check_eq("e7_both_a", rd_a, 64'hDEAD_BEEF_DEAD_BEEF);
    check_eq("e7_both_b", rd_b, 64'hDEAD_BEEF_DEAD_BEEF);
    check_eq("wr_nodrop", drop_a, 1'b0);
    set_rd(5'd7, 5'd8);
    check_eq("e8_zero", rd_a, 64'h0000_0000_DEAD_BEEF);

    // Test 3: zero register
    RegWrite  = 1'b1;
    WriteReg  = 5'd0;
    WriteData = 32'h1234_5678;
    step();
    RegWrite = 1'b0;
    set_rd(5'd0, 5'd0);
    check_eq("zreg_a", rd_a, 64'h0);
    check_eq("zreg_nodrop", drop_a, 1'b0);
    check_eq("nozreg_b", rd_b, 64'h1234_5678_1234_5678);

    // Test 4: bypass versus no bypass
    RegWrite  = 1'b1;
    WriteReg  = 5'd5;
    WriteData = 32'h1;
    step();
    WriteData = 32'hA5A5_A5A5;
    set_rd(5'd5, 5'd6);
    check_eq("byp_a", rd_a[31:0], 32'hA5A5_A5A5);
    check_eq("nobyp_b_old", rd_b[31:0], 32'h1);
    step();
    RegWrite = 1'b0;
    #1;
    check_eq("after_a", rd_a[31:0], 32'hA5A5_A5A5);
    check_eq("after_b", rd_b[31:0], 32'hA5A5_A5A5);

    // Test 5: fill, clear request with a concurrent write, ignored re-request
    for (int i = 1; i < 32; i++) begin
      RegWrite  = 1'b1;
      WriteReg  = 5'(i);
      WriteData = 32'h1000_0000 + 32'(i);
      step();
    end
    RegWrite = 1'b0;
    set_rd(5'd3, 5'd31);
    check_eq("fill_a", rd_a, 64'h1000_001F_1000_0003);
    check_eq("fill_b", rd_b, 64'h1000_001F_1000_0003);
    ClearReq  = 1'b1;
    RegWrite  = 1'b1;
    WriteReg  = 5'd3;
    WriteData = 32'h0000_0BAD;
    #1;
    check_eq("clrreq_nobyp", rd_a[31:0], 32'h1000_0003);
    step();
    ClearReq = 1'b0;
    RegWrite = 1'b0;
    check_eq("clrreq_drop", drop_a, 1'b1);
    check_eq("clrreq_ready", ready_a, 1'b0);
    repeat (4) step();
    ClearReq = 1'b1;
    step();
    ClearReq = 1'b0;
    wait_ready("rise_clrreq", 27);
    for (int e = 0; e < 32; e++) begin
      set_rd(5'(e), 5'(31 - e));
      check_eq($sformatf("swept_a_%0d", e), rd_a, 64'h0);
      check_eq($sformatf("swept_b_%0d", e), rd_b, 64'h0);
    end

    // Test 6: reset in the middle of a sweep restarts it
    ClearReq = 1'b1;
    step();
    ClearReq = 1'b0;
    repeat (10) step();
    rst_n = 1'b0;
    step();
    check_eq("midrst_ready", ready_a, 1'b0);
    check_eq("midrst_drop", drop_a, 1'b0);
    rst_n = 1'b1;
    wait_ready("rise_midreset", 32);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
